// File: rtl/mul_result_writeback.sv
// Buffers one 67-bit Booth product and returns it as LO then HI 32-bit beats over valid/ready.
// Latency 1 from prod_valid to LO beat; a product arriving while busy is dropped and flagged.
module mul_result_writeback #(
  parameter int DATA_W = 32,
  parameter int PROD_W = 2*DATA_W+3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] product,
  output logic              prod_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_ovf,
  output logic              drop_err,
  output logic [CNT_W-1:0]  res_cnt
);

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

  state_t                       state;
  logic [DATA_W-1:0]            hi_buf;
  logic [PROD_W-2*DATA_W:0]     sign_bits;
  logic                         ovf_in;
  logic                         take;

  // The product fits in 2*DATA_W signed bits only if all redundant sign bits match bit 2*DATA_W-1.
  assign sign_bits  = product[PROD_W-1:2*DATA_W-1];
  assign ovf_in     = ~(&sign_bits | ~|sign_bits);
  assign prod_ready = (state == IDLE) | ((state == SEND_HI) & out_ready);
  assign take       = prod_valid & prod_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hi_buf    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ovf   <= 1'b0;
      drop_err  <= 1'b0;
      res_cnt   <= '0;
    end else begin
      if (prod_valid && !prod_ready)
        drop_err <= 1'b1;

      if ((state == SEND_HI) && out_ready)
        res_cnt <= res_cnt + 1'b1;

      // Capture covers both the idle case and the back-to-back case at the HI handoff.
      if (take) begin
        hi_buf    <= product[2*DATA_W-1:DATA_W];
        out_data  <= product[DATA_W-1:0];
        out_valid <= 1'b1;
        out_last  <= 1'b0;
        out_ovf   <= ovf_in;
        state     <= SEND_LO;
      end else begin
        case (state)
          IDLE: ;
          SEND_LO: begin
            if (out_ready) begin
              out_data <= hi_buf;
              out_last <= 1'b1;
              state    <= SEND_HI;
            end
          end
          SEND_HI: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_result_writeback.sv
// Bench for mul_result_writeback: directed vector table, hand sequences, then random traffic vs a beat-queue model.
module tb_mul_result_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        prod_valid;
  logic [66:0] product;
  logic        prod_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ovf;
  logic        drop_err;
  logic [15:0] res_cnt;

  int n_cmp = 0;
  int n_err = 0;

  mul_result_writeback dut (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .product(product),
    .prod_ready(prod_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_ovf(out_ovf),
    .drop_err(drop_err), .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [66:0] p;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ovf;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        o;
  } beat_t;

  localparam logic signed [66:0] PMAX = 67'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [66:0] PMIN = -PMAX - 67'sd1;

  vec_t        vt[7];
  beat_t       q[$];
  logic [15:0] e_cnt;
  logic        m_drop;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic ref_ovf(input logic [66:0] p);
    logic signed [66:0] ps;
    ps = p;
    return (ps > PMAX) || (ps < PMIN);
  endfunction

  task automatic run_vec(input int i);
    prod_valid = 1'b1; product = vt[i].p; out_ready = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    chk($sformatf("v%0d lo valid", i), 64'(out_valid), 64'd1);
    chk($sformatf("v%0d lo data", i), 64'(out_data), 64'(vt[i].lo));
    chk($sformatf("v%0d lo last", i), 64'(out_last), 64'd0);
    chk($sformatf("v%0d lo ovf", i), 64'(out_ovf), 64'(vt[i].ovf));
    @(negedge clk);
    chk($sformatf("v%0d hi data", i), 64'(out_data), 64'(vt[i].hi));
    chk($sformatf("v%0d hi last", i), 64'(out_last), 64'd1);
    chk($sformatf("v%0d hi ovf", i), 64'(out_ovf), 64'(vt[i].ovf));
    e_cnt++;
    @(negedge clk);
    chk($sformatf("v%0d idle valid", i), 64'(out_valid), 64'd0);
    chk($sformatf("v%0d res_cnt", i), 64'(res_cnt), 64'(e_cnt));
  endtask

  initial begin
    vt[0] = '{67'd6,                        32'h0000_0006, 32'h0000_0000, 1'b0};
    vt[1] = '{{67{1'b1}},                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vt[2] = '{67'h0_7FFF_FFFF_FFFF_FFFF,    32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0};
    vt[3] = '{67'h7_8000_0000_0000_0000,    32'h0000_0000, 32'h8000_0000, 1'b0};
    vt[4] = '{67'h0_8000_0000_0000_0001,    32'h0000_0001, 32'h8000_0000, 1'b1};
    vt[5] = '{67'h6_1234_5678_9ABC_DEF0,    32'h9ABC_DEF0, 32'h1234_5678, 1'b1};
    vt[6] = '{67'h7_7FFF_FFFF_0000_0003,    32'h0000_0003, 32'h7FFF_FFFF, 1'b1};

    rst = 1'b1; prod_valid = 1'b0; product = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_last", 64'(out_last), 64'd0);
    chk("rst out_ovf", 64'(out_ovf), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    chk("rst drop_err", 64'(drop_err), 64'd0);
    chk("rst res_cnt", 64'(res_cnt), 64'd0);
    chk("rst prod_ready", 64'(prod_ready), 64'd1);
    rst = 1'b0; e_cnt = '0;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Overflowing product held under backpressure
    prod_valid = 1'b1; product = 67'h4_0000_0000_0000_0000; out_ready = 1'b0;
    @(negedge clk);
    prod_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("hold%0d data", k), 64'(out_data), 64'd0);
      chk($sformatf("hold%0d last", k), 64'(out_last), 64'd0);
      chk($sformatf("hold%0d ovf", k), 64'(out_ovf), 64'd1);
      @(negedge clk);
    end
    chk("hold still valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold hi data", 64'(out_data), 64'd0);
    chk("hold hi last", 64'(out_last), 64'd1);
    chk("hold hi ovf", 64'(out_ovf), 64'd1);
    e_cnt++;
    @(negedge clk);
    chk("hold res_cnt", 64'(res_cnt), 64'(e_cnt));

    // Back-to-back: new product accepted in the HI-accept cycle
    prod_valid = 1'b1; product = 67'd6;
    @(negedge clk);
    prod_valid = 1'b0;
    chk("b2b lo1", 64'(out_data), 64'd6);
    @(negedge clk);
    chk("b2b hi1 last", 64'(out_last), 64'd1);
    chk("b2b ready at hi", 64'(prod_ready), 64'd1);
    prod_valid = 1'b1; product = 67'd9;
    @(negedge clk);
    prod_valid = 1'b0;
    e_cnt++;
    chk("b2b lo2 valid", 64'(out_valid), 64'd1);
    chk("b2b lo2 data", 64'(out_data), 64'd9);
    chk("b2b lo2 last", 64'(out_last), 64'd0);
    chk("b2b drop_err", 64'(drop_err), 64'd0);
    chk("b2b res_cnt", 64'(res_cnt), 64'(e_cnt));
    @(negedge clk);
    chk("b2b hi2 data", 64'(out_data), 64'd0);
    e_cnt++;
    @(negedge clk);
    chk("b2b idle", 64'(out_valid), 64'd0);
    chk("b2b res_cnt2", 64'(res_cnt), 64'(e_cnt));

    // Product arriving during SEND_LO is dropped
    prod_valid = 1'b1; product = 67'h0_1234_5678_9ABC_DEF0; out_ready = 1'b0;
    @(negedge clk);
    chk("drop ready low", 64'(prod_ready), 64'd0);
    product = 67'd77;
    @(negedge clk);
    prod_valid = 1'b0;
    chk("drop flag", 64'(drop_err), 64'd1);
    chk("drop lo intact", 64'(out_data), 64'h9ABC_DEF0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("drop hi intact", 64'(out_data), 64'h1234_5678);
    e_cnt++;
    @(negedge clk);
    chk("drop idle", 64'(out_valid), 64'd0);
    chk("drop res_cnt", 64'(res_cnt), 64'(e_cnt));
    chk("drop sticky", 64'(drop_err), 64'd1);

    // Reset during SEND_HI under backpressure
    prod_valid = 1'b1; product = 67'h0_AAAA_BBBB_CCCC_DDDD;
    @(negedge clk);
    prod_valid = 1'b0;
    @(negedge clk);
    chk("rstx at hi", 64'(out_last), 64'd1);
    out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstx valid", 64'(out_valid), 64'd0);
    chk("rstx res_cnt", 64'(res_cnt), 64'd0);
    chk("rstx drop", 64'(drop_err), 64'd0);
    chk("rstx data", 64'(out_data), 64'd0);
    chk("rstx ready", 64'(prod_ready), 64'd1);

    // Random traffic against a queue-of-beats model
    q.delete(); e_cnt = '0; m_drop = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        rdy_m;
      logic [63:0] lo64;
      logic [2:0]  r3;
      chk("rnd valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("rnd data", 64'(out_data), 64'(q[0].d));
        chk("rnd last", 64'(out_last), 64'(q[0].l));
        chk("rnd ovf", 64'(out_ovf), 64'(q[0].o));
      end
      chk("rnd res_cnt", 64'(res_cnt), 64'(e_cnt));
      chk("rnd drop_err", 64'(drop_err), 64'(m_drop));

      rst        = ($urandom_range(0, 249) == 0);
      prod_valid = ($urandom_range(0, 2) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      lo64       = {$urandom, $urandom};
      r3         = 3'($urandom_range(0, 7));
      product    = ($urandom_range(0, 1) == 0) ? {{3{lo64[63]}}, lo64} : {r3, lo64};
      #1;
      rdy_m = (q.size() == 0) || (q.size() == 1 && out_ready);
      if (rst) begin
        q.delete(); e_cnt = '0; m_drop = 1'b0;
      end else begin
        chk("rnd prod_ready", 64'(prod_ready), 64'(rdy_m));
        if (out_ready && q.size() != 0) begin
          if (q[0].l) e_cnt++;
          void'(q.pop_front());
        end
        if (prod_valid && !rdy_m) m_drop = 1'b1;
        if (prod_valid && rdy_m) begin
          q.push_back('{product[31:0], 1'b0, ref_ovf(product)});
          q.push_back('{product[63:32], 1'b1, ref_ovf(product)});
        end
      end
      @(negedge clk);
    end
    prod_valid = 1'b0; rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
